// File: rtl/space_invaders_pkg.sv
// Shared constants and types for the space-invaders datapath blocks.
// Screen geometry, sprite sizes, colours and the shot engine state encoding.
package space_invaders_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int USER_W   = 20;
  localparam int USER_Y   = 220;

  localparam logic [2:0] COL_BLACK = 3'b000;
  localparam logic [2:0] COL_WHITE = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ERASE = 3'd1,
    S_STEP  = 3'd2,
    S_DRAW  = 3'd3,
    S_DONE  = 3'd4
  } shot_state_e;

endpackage

// File: rtl/rect_scanner.sv
// Row-major rectangle scanner: col runs fastest, wraps to zero after the last pixel.
// Counters sit at zero whenever go is low so every scan starts at the top-left corner.
module rect_scanner #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          go,
  input  logic [CW-1:0] width,
  input  logic [CW-1:0] height,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          last
);

  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          col_end;
  logic          row_end;

  assign col_end = (col_q == width - CW'(1));
  assign row_end = (row_q == height - CW'(1));

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (!go) begin
      col_d = '0;
      row_d = '0;
    end else if (col_end) begin
      col_d = '0;
      row_d = row_end ? '0 : row_q + CW'(1);
    end else begin
      col_d = col_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = go && col_end && row_end;

endmodule

// File: rtl/player_shot_engine.sv
// Player projectile engine: once per frame erases, advances and redraws the single shot,
// streaming one pixel per cycle to the controller's pixel mux.
module player_shot_engine
  import space_invaders_pkg::*;
#(
  parameter int         SHOT_W      = 2,
  parameter int         SHOT_H      = 6,
  parameter int         SHOT_SPEED  = 4,
  parameter int         LAUNCH_Y    = 214,
  parameter int         LAUNCH_DX   = 9,
  parameter int         Y_TOP       = 0,
  parameter logic [2:0] SHOT_COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       fire,
  input  logic [8:0] user_x,
  input  logic       start,
  input  logic       hit,
  output logic [8:0] X,
  output logic [7:0] Y,
  output logic [2:0] colour,
  output logic       plot_valid,
  output logic       done,
  output logic       busy,
  output logic       shot_active,
  output logic [8:0] shot_x,
  output logic [7:0] shot_y
);

  localparam int         CW       = 4;
  localparam logic [7:0] RETIRE_Y = 8'(Y_TOP + SHOT_SPEED);

  shot_state_e state_q, state_d;
  logic        fire_q, fire_d;
  logic        fire_pending_q, fire_pending_d;
  logic        hit_pending_q, hit_pending_d;
  logic        shot_active_q, shot_active_d;
  logic [8:0]  shot_x_q, shot_x_d;
  logic [7:0]  shot_y_q, shot_y_d;

  logic          scan_go;
  logic          scan_last;
  logic [CW-1:0] scan_col;
  logic [CW-1:0] scan_row;
  logic          fire_edge;

  assign scan_go   = (state_q == S_ERASE) || (state_q == S_DRAW);
  assign fire_edge = fire && !fire_q;

  rect_scanner #(.CW(CW)) u_scan (
    .clk    (clk),
    .resetn (resetn),
    .go     (scan_go),
    .width  (CW'(SHOT_W)),
    .height (CW'(SHOT_H)),
    .col    (scan_col),
    .row    (scan_row),
    .last   (scan_last)
  );

  always_comb begin
    state_d        = state_q;
    fire_d         = fire;
    fire_pending_d = fire_pending_q;
    hit_pending_d  = hit_pending_q;
    shot_active_d  = shot_active_q;
    shot_x_d       = shot_x_q;
    shot_y_d       = shot_y_q;

    if (fire_edge && !shot_active_q) fire_pending_d = 1'b1;
    if (hit && shot_active_q)        hit_pending_d  = 1'b1;

    case (state_q)
      S_IDLE:  if (start) state_d = shot_active_q ? S_ERASE : S_STEP;
      S_ERASE: if (scan_last) state_d = S_STEP;
      S_STEP: begin
        if (hit_pending_q) begin
          shot_active_d = 1'b0;
        end else if (shot_active_q && (shot_y_q < RETIRE_Y)) begin
          shot_active_d = 1'b0;
        end else if (shot_active_q) begin
          shot_y_d = shot_y_q - 8'(SHOT_SPEED);
        end else if (fire_pending_q) begin
          shot_x_d       = user_x + 9'(LAUNCH_DX);
          shot_y_d       = 8'(LAUNCH_Y);
          shot_active_d  = 1'b1;
          fire_pending_d = 1'b0;
        end
        // a hit arriving now belongs to the shot as it stands after this step
        hit_pending_d = hit && shot_active_d;
        state_d       = shot_active_d ? S_DRAW : S_DONE;
      end
      S_DRAW:  if (scan_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= S_IDLE;
      fire_q         <= 1'b0;
      fire_pending_q <= 1'b0;
      hit_pending_q  <= 1'b0;
      shot_active_q  <= 1'b0;
      shot_x_q       <= '0;
      shot_y_q       <= '0;
    end else begin
      state_q        <= state_d;
      fire_q         <= fire_d;
      fire_pending_q <= fire_pending_d;
      hit_pending_q  <= hit_pending_d;
      shot_active_q  <= shot_active_d;
      shot_x_q       <= shot_x_d;
      shot_y_q       <= shot_y_d;
    end
  end

  assign plot_valid  = scan_go;
  assign X           = scan_go ? shot_x_q + 9'(scan_col) : '0;
  assign Y           = scan_go ? shot_y_q + 8'(scan_row) : '0;
  assign colour      = (state_q == S_DRAW) ? SHOT_COLOUR : COL_BLACK;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);
  assign shot_active = shot_active_q;
  assign shot_x      = shot_x_q;
  assign shot_y      = shot_y_q;

endmodule
